// File: rtl/cdc_handshake_rx.sv
// Receive side of a toggle-request / toggle-acknowledge clock-domain crossing.
// Optional feature: define CDC_HANDSHAKE_RX_OVERRUN_DET_EN to add sticky overrun_o.
module cdc_handshake_rx #(
   parameter int DATA_WIDTH  = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_async_i,
   input  logic [DATA_WIDTH-1:0] data_async_i,
   output logic                  ack_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [15:0]           xfer_cnt_o
`ifdef CDC_HANDSHAKE_RX_OVERRUN_DET_EN
   ,
   output logic                  overrun_o
`endif
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_chain;
   logic                   req_sync;
   logic                   req_seen;
   logic [15:0]            xfer_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_chain <= '0;
      end else begin
         sync_chain <= {sync_chain[SYNC_STAGES-2:0], req_async_i};
      end
   end

   assign req_sync   = sync_chain[SYNC_STAGES-1];
   assign xfer_cnt_o = xfer_cnt;

   // Requests are only consumed from IDLE, so a word accepted at one edge
   // frees the block for the next request on the following edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         req_seen <= 1'b0;
         ack_o    <= 1'b0;
         data_o   <= '0;
         valid_o  <= 1'b0;
         xfer_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_sync != req_seen) begin
                  data_o   <= data_async_i;
                  req_seen <= req_sync;
                  valid_o  <= 1'b1;
                  state    <= HOLD;
               end
            end
            HOLD: begin
               if (ready_i) begin
                  valid_o  <= 1'b0;
                  ack_o    <= ~ack_o;
                  xfer_cnt <= xfer_cnt + 16'd1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CDC_HANDSHAKE_RX_OVERRUN_DET_EN
   // A request edge seen while a word is still held means the source
   // toggled again before its acknowledge arrived.
   always_ff @(posedge clk) begin
      if (reset) begin
         overrun_o <= 1'b0;
      end else if (state == HOLD && req_sync != req_seen) begin
         overrun_o <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Bench for cdc_handshake_rx: directed protocol cases plus randomized transfers
// checked against a cycle-counting model of the toggle handshake.
module tb_cdc_handshake_rx;

   localparam int SYNC = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        reqAsync;
   logic [31:0] dataAsync;
   logic        ackOut;
   logic [31:0] dataOut;
   logic        validOut;
   logic        ready;
   logic [15:0] xferCnt;
`ifdef CDC_HANDSHAKE_RX_OVERRUN_DET_EN
   logic        overrun;
`endif

   int checkCount = 0;
   int passCount  = 0;

   cdc_handshake_rx #(
      .DATA_WIDTH (32),
      .SYNC_STAGES(SYNC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_async_i (reqAsync),
      .data_async_i(dataAsync),
      .ack_o       (ackOut),
      .data_o      (dataOut),
      .valid_o     (validOut),
      .ready_i     (ready),
      .xfer_cnt_o  (xferCnt)
`ifdef CDC_HANDSHAKE_RX_OVERRUN_DET_EN
      ,
      .overrun_o   (overrun)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic newReq, input logic [31:0] newData, input logic newReady);
      reqAsync  = newReq;
      dataAsync = newData;
      ready     = newReady;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
   endtask

   task automatic doReset();
      reset = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0);
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Per-cycle model state for the randomized phase.
   logic        expValid;
   logic        expAck;
   logic [15:0] expCnt;
   logic [31:0] expData;
   logic        reqLevel;
   logic        readyNow;
   logic        accepted;
   logic        sawValid;
   logic [31:0] word;
   int          budget;
   int          n;

   initial begin
      reset = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0);
      @(negedge clk);

      // Reset state
      doReset();
      checkOutput("reset_valid", 64'(validOut), 64'd0);
      checkOutput("reset_data",  64'(dataOut),  64'd0);
      checkOutput("reset_ack",   64'(ackOut),   64'd0);
      checkOutput("reset_cnt",   64'(xferCnt),  64'd0);

      // Single transfer with exact latency
      applyStimulus(1'b1, 32'hDEADBEEF, 1'b1);
      for (int e = 1; e <= SYNC; e++) begin
         tick();
         checkOutput("single_early_valid", 64'(validOut), 64'd0);
      end
      tick();
      checkOutput("single_valid", 64'(validOut), 64'd1);
      checkOutput("single_data",  64'(dataOut),  64'hDEADBEEF);
      checkOutput("single_ack_before", 64'(ackOut), 64'd0);
      tick();
      checkOutput("single_ack",   64'(ackOut),   64'd1);
      checkOutput("single_valid_clr", 64'(validOut), 64'd0);
      checkOutput("single_cnt",   64'(xferCnt),  64'd1);

      // Backpressure
      applyStimulus(1'b0, 32'h12345678, 1'b0);
      for (int e = 0; e <= SYNC; e++) tick();
      checkOutput("bp_valid", 64'(validOut), 64'd1);
      for (int c = 0; c < 10; c++) begin
         tick();
         checkOutput("bp_hold", 64'({validOut, ackOut, dataOut}), 64'({1'b1, 1'b1, 32'h12345678}));
      end
      ready = 1'b1;
      tick();
      checkOutput("bp_ack",   64'(ackOut),   64'd0);
      checkOutput("bp_valid_clr", 64'(validOut), 64'd0);
      checkOutput("bp_cnt",   64'(xferCnt),  64'd2);
      for (int c = 0; c < 4; c++) tick();
      checkOutput("bp_single_ack", 64'({ackOut, xferCnt}), 64'({1'b0, 16'd2}));

      // Back-to-back: re-toggle on every acknowledge
      doReset();
      reqLevel = 1'b0;
      expAck   = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         reqLevel = ~reqLevel;
         applyStimulus(reqLevel, 32'(i), 1'b1);
         budget = 0;
         while (validOut !== 1'b1 && budget < 20) begin
            tick();
            budget++;
         end
         checkOutput("b2b_valid", 64'(validOut), 64'd1);
         checkOutput("b2b_data",  64'(dataOut),  64'(i));
         budget = 0;
         while (ackOut === expAck && budget < 20) begin
            tick();
            budget++;
         end
         expAck = ~expAck;
         checkOutput("b2b_ack_toggle", 64'(ackOut), 64'(expAck));
      end
      sawValid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         sawValid |= validOut;
      end
      checkOutput("b2b_no_dup", 64'(sawValid), 64'd0);
      checkOutput("b2b_cnt",    64'(xferCnt),  64'd4);
      checkOutput("b2b_ack",    64'(ackOut),   64'd0);

      // Reset while holding a word, with the request line left high
      applyStimulus(1'b1, 32'hCAFEF00D, 1'b0);
      for (int e = 0; e <= SYNC; e++) tick();
      checkOutput("rst_mid_hold", 64'(validOut), 64'd1);
      reset = 1'b1;
      tick();
      checkOutput("rst_mid_state", 64'({validOut, ackOut, xferCnt, dataOut}), 64'd0);
      reset = 1'b0;
      for (int e = 1; e <= SYNC; e++) begin
         tick();
         checkOutput("rst_pending_early", 64'(validOut), 64'd0);
      end
      tick();
      checkOutput("rst_pending_valid", 64'({validOut, ackOut, dataOut}), 64'({1'b1, 1'b0, 32'hCAFEF00D}));
      ready = 1'b1;
      tick();
      checkOutput("rst_pending_accept", 64'({validOut, ackOut, xferCnt}), 64'({1'b0, 1'b1, 16'd1}));

      // Counter wrap: preload the count, then run two transfers
      doReset();
      dut.xfer_cnt = 16'hFFFE;
      applyStimulus(1'b1, 32'h0BADCAFE, 1'b1);
      for (int e = 0; e <= SYNC + 1; e++) tick();
      checkOutput("wrap_ffff", 64'(xferCnt), 64'hFFFF);
      applyStimulus(1'b0, 32'h0BADCAFF, 1'b1);
      for (int e = 0; e <= SYNC + 1; e++) tick();
      checkOutput("wrap_zero", 64'({xferCnt, ackOut, validOut}), 64'({16'h0000, 1'b0, 1'b0}));

`ifdef CDC_HANDSHAKE_RX_OVERRUN_DET_EN
      // Overrun: two request toggles while a word is held
      doReset();
      checkOutput("ovr_reset", 64'(overrun), 64'd0);
      applyStimulus(1'b1, 32'hA5A5A5A5, 1'b0);
      for (int e = 0; e <= SYNC; e++) tick();
      reqAsync = 1'b0;
      tick();
      reqAsync = 1'b1;
      for (int e = 1; e <= SYNC; e++) tick();
      checkOutput("ovr_set", 64'({overrun, validOut, dataOut}), 64'({1'b1, 1'b1, 32'hA5A5A5A5}));
      ready = 1'b1;
      for (int c = 0; c < 6; c++) tick();
      checkOutput("ovr_sticky", 64'({overrun, validOut}), 64'({1'b1, 1'b0}));
      doReset();
      checkOutput("ovr_cleared", 64'(overrun), 64'd0);
`endif

      // Randomized transfers against the handshake model
      doReset();
      expValid = 1'b0;
      expAck   = 1'b0;
      expCnt   = 16'd0;
      expData  = 32'd0;
      reqLevel = 1'b0;
      for (int t = 0; t < 150; t++) begin
         for (int g = $urandom_range(0, 3); g > 0; g--) begin
            ready = 1'($urandom_range(0, 1));
            tick();
            checkOutput("rand_idle", {14'd0, validOut, ackOut, xferCnt, dataOut}, {14'd0, expValid, expAck, expCnt, expData});
         end
         word     = $urandom;
         reqLevel = ~reqLevel;
         applyStimulus(reqLevel, word, 1'($urandom_range(0, 1)));
         n        = 0;
         accepted = 1'b0;
         while (!accepted && n < 40) begin
            readyNow = ready;
            tick();
            n++;
            if (n == SYNC + 1) begin
               expValid = 1'b1;
               expData  = word;
            end else if (expValid && readyNow) begin
               expValid = 1'b0;
               expAck   = ~expAck;
               expCnt   = expCnt + 16'd1;
               accepted = 1'b1;
            end
            checkOutput("rand_xfer", {14'd0, validOut, ackOut, xferCnt, dataOut}, {14'd0, expValid, expAck, expCnt, expData});
            ready = (n > 30) ? 1'b1 : 1'($urandom_range(0, 1));
         end
         checkOutput("rand_accepted", 64'(accepted), 64'd1);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/cdc_handshake_rx.md
CDC_HANDSHAKE_RX -- requirements
Module: cdc_handshake_rx

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of the crossed data word.
REQ-002 Parameter: SYNC_STAGES, default 2, depth of the request synchronizer chain; legal range 2..4.
REQ-003 Port: clk  input  1  destination-domain clock; all flops SHALL be on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: req_async_i  input  1  toggle-protocol request from the source domain; each toggle SHALL announce one new word.
REQ-006 Port: data_async_i  input  DATA_WIDTH  source-domain data word, held stable by the source from its req toggle until the matching ack toggle.
REQ-007 Port: ack_o  output  1  registered toggle acknowledge returned to the source domain.
REQ-008 Port: data_o  output  DATA_WIDTH  captured word.
REQ-009 Port: valid_o  output  1  data_o holds a word not yet accepted.
REQ-010 Port: ready_i  input  1  consumer accepts data_o.
REQ-011 Port: xfer_cnt_o  output  16  count of completed transfers.

Function
REQ-012 The block SHALL pass req_async_i through a SYNC_STAGES-deep flop chain; req_sync is the output of the last stage.
REQ-013 The block SHALL hold a register req_seen that holds the last request level consumed.
REQ-014 The FSM SHALL have exactly two states: IDLE and HOLD.
REQ-015 In IDLE, on an edge where req_sync != req_seen, the block SHALL do all of the following at that edge: latch data_async_i into data_o, set req_seen to req_sync, set valid_o to 1, and go to HOLD.
REQ-016 Latency: a req_async_i toggle first sampled at edge E1 SHALL make valid_o 1 after edge E(SYNC_STAGES+1).
REQ-017 In HOLD, valid_o SHALL stay 1 and data_o SHALL stay constant until an edge where ready_i=1.
REQ-018 On that accepting edge, the block SHALL do all of the following: clear valid_o, toggle ack_o, increment xfer_cnt_o modulo 2^16, and go to IDLE.
REQ-019 ready_i SHALL be ignored while valid_o=0; ready_i held high continuously SHALL give exactly one acceptance per word.
REQ-020 A new request SHALL NOT be consumed in the same edge that accepts the previous word; it is evaluated from IDLE at the next edge.
REQ-021 Minimum spacing between two valid_o rising edges SHALL be 2 cycles.
REQ-022 xfer_cnt_o SHALL wrap from 16'hFFFF to 16'h0000 with no flag.
REQ-023 A req_sync change observed while in HOLD SHALL NOT alter data_o, valid_o or req_seen.
REQ-024 ack_o and data_o SHALL be flop outputs with no combinational path from any input.

Reset
REQ-025 While reset=1 at an edge, the block SHALL clear all of the following to 0: the synchronizer stages, req_seen, ack_o, data_o, valid_o and xfer_cnt_o; the FSM SHALL go to IDLE.
REQ-026 Reset asserted in HOLD SHALL drop the pending word without toggling ack_o; the source domain is reset together with this block.
REQ-027 The first edge after reset release SHALL evaluate requests normally, so a req_async_i already at 1 SHALL be treated as a pending request.

Configuration
REQ-028 Macro CDC_HANDSHAKE_RX_OVERRUN_DET_EN: when defined, the block SHALL add output port overrun_o (1 bit).
REQ-029 overrun_o SHALL be a sticky flag, set on any edge in HOLD where req_sync != req_seen (source toggled twice before receiving ack).
REQ-030 overrun_o SHALL be cleared only by reset.
REQ-031 When CDC_HANDSHAKE_RX_OVERRUN_DET_EN is undefined, port overrun_o and its logic SHALL be absent, and the behaviour of all other ports SHALL be identical.

Verification
REQ-032 Single transfer: SYNC_STAGES=2, data_async_i=32'hDEADBEEF, toggle req_async_i 0->1 before E1, ready_i=1 -> valid_o=1 after E3 with data_o=32'hDEADBEEF; ack_o=1, valid_o=0 and xfer_cnt_o=1 after E4.
REQ-033 Backpressure: ready_i=0 for 10 cycles after valid_o rises -> valid_o and data_o stay constant and ack_o does not toggle; ready_i=1 -> exactly one ack_o toggle.
REQ-034 Back-to-back: source re-toggles req_async_i on each ack_o toggle with data 1,2,3,4 -> data_o sequence is 1,2,3,4, no duplicates, xfer_cnt_o=4, ack_o=0.
REQ-035 Reset mid-transfer: reset=1 in HOLD -> next edge valid_o=0, data_o=0, ack_o=0, xfer_cnt_o=0, FSM in IDLE.
REQ-036 Wrap: preload 65535 transfers, then one more -> xfer_cnt_o=16'h0000.
REQ-037 Overrun (macro defined): toggle req_async_i twice while in HOLD -> overrun_o=1 after SYNC_STAGES+1 edges and stays 1 until reset; data_o is unchanged.
